// File: rtl/noise_ema_subtract.sv
// noise_ema_subtract
//   Per-lane background (noise) estimator and subtractor for a multi-lane
//   sample stream. Each lane keeps an exponential moving average accumulator
//   bg[i] carrying SHIFT fraction bits. The integer estimate bg[i] >>> SHIFT is
//   subtracted from every accepted frame, and the difference is saturated back
//   to DW bits. Frames flagged with learn also update the accumulators.
//   The pipeline has two stages: S1 captures the frame and its estimate, and
//   S2 does the subtraction and saturation into registered outputs.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input frame valid
//   in_ready   out  frame accepted this cycle when in_valid is also high
//   in_data    in   LANES x DW signed samples, lane i at [DW*i +: DW]
//   learn      in   accepted frame also updates the noise estimate
//   clear_bg   in   zero all accumulators and the learn counter
//   out_valid  out  output frame valid
//   out_ready  in   downstream accepts the output frame
//   out_data   out  noise-removed saturated samples, same packing as in_data
//   out_sat    out  per-lane flag, set when that lane was clipped
//   bg_valid   out  learn counter has reached LEARN_MIN
module noise_ema_subtract #(
    parameter int LANES     = 16,
    parameter int DW        = 8,
    parameter int SHIFT     = 4,
    parameter int NW        = 16,
    parameter int LEARN_MIN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  learn,
    input  logic                  clear_bg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      out_sat,
    output logic                  bg_valid
);

    localparam int CW = $clog2(LEARN_MIN + 1);
    // The difference is formed one bit wider than the accumulator, so it
    // cannot overflow for any sample/estimate pair.
    localparam int XW = NW + 1;
    localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (DW - 1)) - 1);
    localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

    logic signed [NW-1:0] bg_q     [LANES];
    logic [CW-1:0]        cnt_q;

    logic                 s1_valid_q;
    logic signed [DW-1:0] s1_x_q   [LANES];
    logic signed [NW-1:0] s1_est_q [LANES];

    logic                 out_valid_q;
    logic [LANES*DW-1:0]  out_data_q;
    logic [LANES-1:0]     out_sat_q;

    logic                 s2_adv;
    logic                 accept;

    logic signed [DW-1:0] lane_x   [LANES];
    logic signed [NW-1:0] est      [LANES];
    logic signed [NW-1:0] bg_d     [LANES];
    logic signed [XW-1:0] diff     [LANES];
    logic [LANES*DW-1:0]  sat_data_d;
    logic [LANES-1:0]     sat_flag_d;

    // in_ready depends only on registered state and out_ready.
    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign bg_valid  = (cnt_q == CW'(LEARN_MIN));

    always_comb begin
        sat_data_d = '0;
        sat_flag_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_x[i] = $signed(in_data[DW*i +: DW]);
            est[i]    = bg_q[i] >>> SHIFT;
            bg_d[i]   = bg_q[i] + {{(NW-DW){lane_x[i][DW-1]}}, lane_x[i]} - est[i];

            diff[i] = {{(XW-DW){s1_x_q[i][DW-1]}}, s1_x_q[i]}
                    - {s1_est_q[i][NW-1], s1_est_q[i]};
            if (diff[i] > SAT_HI) begin
                sat_data_d[DW*i +: DW] = SAT_HI[DW-1:0];
                sat_flag_d[i]          = 1'b1;
            end else if (diff[i] < SAT_LO) begin
                sat_data_d[DW*i +: DW] = SAT_LO[DW-1:0];
                sat_flag_d[i]          = 1'b1;
            end else begin
                sat_data_d[DW*i +: DW] = diff[i][DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                bg_q[i]     <= '0;
                s1_x_q[i]   <= '0;
                s1_est_q[i] <= '0;
            end
        end else begin
            // S1: the estimate is captured from bg before this frame's update.
            if (accept) begin
                s1_valid_q <= 1'b1;
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_x_q[i]   <= lane_x[i];
                    s1_est_q[i] <= est[i];
                end
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end

            // S2: holds its contents while stalled by the downstream.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= sat_data_d;
                    out_sat_q  <= sat_flag_d;
                end
            end

            // Estimator: clear_bg takes priority over a same-cycle learn frame.
            if (clear_bg) begin
                cnt_q <= '0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    bg_q[i] <= '0;
                end
            end else if (accept && learn) begin
                if (cnt_q != CW'(LEARN_MIN)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                for (int unsigned i = 0; i < LANES; i++) begin
                    bg_q[i] <= bg_d[i];
                end
            end
        end
    end

endmodule

// File: doc/noise_ema_subtract.md
NOISE_EMA_SUBTRACT -- requirements
Module: noise_ema_subtract

Interface
REQ-001 SHALL have parameter LANES, default 16, number of parallel sample lanes.
REQ-002 SHALL have parameter DW, default 8, signed sample width per lane.
REQ-003 SHALL have parameter SHIFT, default 4, EMA weight 2^-SHIFT; estimator fraction bits.
REQ-004 SHALL have parameter NW, default 16, signed per-lane accumulator width; NW >= DW+SHIFT+1.
REQ-005 SHALL have parameter LEARN_MIN, default 64, learn frames before bg_valid.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  in  1  input frame valid.
REQ-009 SHALL have port in_ready  out  1  block accepts frame this cycle.
REQ-010 SHALL have port in_data  in  LANES*DW  lane i at [DW*i +: DW], signed.
REQ-011 SHALL have port learn  in  1  accepted frame also updates noise estimate; sampled with the frame.
REQ-012 SHALL have port clear_bg  in  1  zero all accumulators and learn counter.
REQ-013 SHALL have port out_valid  out  1  output frame valid.
REQ-014 SHALL have port out_ready  in  1  downstream accepts output.
REQ-015 SHALL have port out_data  out  LANES*DW  noise-removed, saturated samples, same packing.
REQ-016 SHALL have port out_sat  out  LANES  per-lane saturation flag for out_data.
REQ-017 SHALL have port bg_valid  out  1  learn counter reached LEARN_MIN.

Function
REQ-018 SHALL accept a frame when in_valid && in_ready; SHALL transfer output when out_valid && out_ready.
REQ-019 SHALL be a 2-stage pipeline (S1 capture, S2 subtract/saturate); latency 2 cycles from acceptance to out_valid with no stall.
REQ-020 SHALL advance S2 when !out_valid || out_ready; S1 advances into S2 on that condition; in_ready = !s1_valid || S2-advance; no combinational in_valid->in_ready path.
REQ-021 SHALL hold out_data, out_sat, out_valid stable while out_valid && !out_ready; no frame lost or duplicated.
REQ-022 SHALL keep per-lane accumulator bg[i] (signed NW); estimate est[i] = bg[i] >>> SHIFT (arithmetic, floor).
REQ-023 SHALL capture est[i] into S1 at acceptance, using bg before that frame's update.
REQ-024 SHALL, on accepted frame with learn=1, update bg[i] <= bg[i] + sext(x[i]) - (bg[i] >>> SHIFT).
REQ-025 SHALL compute d = x[i] - est[i] at DW+1 bits min; saturate to [-2^(DW-1), 2^(DW-1)-1]; out_sat[i]=1 iff clipped.
REQ-026 SHALL count accepted learn frames, saturating at LEARN_MIN; bg_valid = (count == LEARN_MIN).
REQ-027 SHALL, on clear_bg, zero all bg[i] and count next cycle; clear_bg wins over same-cycle learn update; pipeline contents unaffected.
REQ-028 SHALL subtract regardless of bg_valid (bg=0 gives out = in).
REQ-029 SHALL ignore learn and in_data when no frame is accepted.

Reset
REQ-030 SHALL, on rst, clear S1/S2 valid, out_valid=0, out_data=0, out_sat=0, bg[i]=0, count=0, bg_valid=0; in_ready=1 first cycle after rst deasserts.
REQ-031 SHALL, on rst mid-operation, discard in-flight frames; rst overrides clear_bg, learn, all handshakes.

Verification
REQ-032 SHALL verify reset: rst 1 cycle mid-stream -> next cycle out_valid=0, bg_valid=0, in_ready=1; next frame x=5 -> out 5.
REQ-033 SHALL verify convergence: defaults, all lanes x=20, learn=1, out_ready=1, 200 frames -> bg=320, est=20, last outputs 0, bg_valid=1 after frame 64.
REQ-034 SHALL verify saturation: after REQ-033, learn=0, x=127 -> 107, sat=0; x=-128 -> -128, sat=1; bg stays 320.
REQ-035 SHALL verify negative estimate: learn x=-20 from cleared state to convergence -> est=-20; x=120 -> 127 sat=1.
REQ-036 SHALL verify backpressure: 5 back-to-back frames, out_ready=0 cycles 3-8 -> in_ready low once S1,S2 full, out_data stable, all 5 delivered in order.
REQ-037 SHALL verify clear_bg with learn frame same cycle -> bg=0, count=0, bg_valid=0; that frame output uses pre-clear est.
